// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / load-store) arbiter in front
// of a single-outstanding memory port. LSU has priority; a starvation counter
// hands the port to instruction fetch after STARVE_MAX back-to-back LSU grants.
module mem_arbiter #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_req_ready,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_resp_data,

    input  logic            ls_req_valid,
    input  logic [XLEN-1:0] ls_req_addr,
    input  logic            ls_req_wen,
    input  logic [XLEN-1:0] ls_req_wdata,
    input  logic [7:0]      ls_req_wmask,
    output logic            ls_req_ready,
    output logic            ls_resp_valid,
    output logic [XLEN-1:0] ls_resp_data,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    state_t          state;
    owner_t          owner;
    logic [CNT_W-1:0] starve_cnt;
    logic            post_rst;
    logic            req_valid_q;
    logic [XLEN-1:0] addr_q;
    logic            wen_q;
    logic [XLEN-1:0] wdata_q;
    logic [7:0]      wmask_q;

    logic arb_open;
    logic if_wins;
    logic if_grant;
    logic ls_grant;
    logic resp_hit;

    // Arbitration: open only in IDLE, never during or right after reset.
    always_comb begin
        arb_open     = (state == ST_IDLE) && !rst && !post_rst;
        if_wins      = if_req_valid && ((starve_cnt == STARVE_LIM) || !ls_req_valid);
        if_req_ready = arb_open && if_wins;
        ls_req_ready = arb_open && ls_req_valid && !if_wins;
        if_grant     = if_req_valid && if_req_ready;
        ls_grant     = ls_req_valid && ls_req_ready;
    end

    // Response routing: a response only counts while waiting for one.
    always_comb begin
        resp_hit      = (state == ST_WAIT) && mem_resp_valid && !rst;
        if_resp_valid = resp_hit && (owner == OWN_IF);
        ls_resp_valid = resp_hit && (owner == OWN_LS);
        if_resp_data  = mem_resp_data;
        ls_resp_data  = mem_resp_data;
    end

    // Downstream request fields come straight from the capture registers so
    // they stay stable for as long as mem_req_ready is held low.
    always_comb begin
        mem_req_valid = req_valid_q && !rst;
        mem_req_addr  = addr_q;
        mem_req_wen   = wen_q;
        mem_req_wdata = wdata_q;
        mem_req_wmask = wmask_q;
    end

    // Transaction FSM: capture on grant, issue downstream, wait for response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            starve_cnt  <= '0;
            post_rst    <= 1'b1;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            post_rst <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_grant) begin
                        owner       <= OWN_IF;
                        addr_q      <= if_req_addr;
                        wen_q       <= 1'b0;
                        wdata_q     <= '0;
                        wmask_q     <= '0;
                        starve_cnt  <= '0;
                        req_valid_q <= 1'b1;
                        state       <= ST_REQ;
                    end else if (ls_grant) begin
                        owner       <= OWN_LS;
                        addr_q      <= ls_req_addr;
                        wen_q       <= ls_req_wen;
                        wdata_q     <= ls_req_wdata;
                        wmask_q     <= ls_req_wen ? ls_req_wmask : 8'h00;
                        req_valid_q <= 1'b1;
                        state       <= ST_REQ;
                        if (!if_req_valid) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_LIM) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data/address width in bits.
REQ-002 Parameter STARVE_MAX, default 4, max consecutive LSU grants while IF waits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req_valid  input  1  instruction-fetch read request.
REQ-006 if_req_addr  input  XLEN  fetch address.
REQ-007 if_req_ready  output  1  fetch request accepted this cycle.
REQ-008 if_resp_valid  output  1  fetch data valid, one-cycle pulse.
REQ-009 if_resp_data  output  XLEN  fetch read data.
REQ-010 ls_req_valid  input  1  load/store request.
REQ-011 ls_req_addr  input  XLEN  load/store address.
REQ-012 ls_req_wen  input  1  1 = store, 0 = load.
REQ-013 ls_req_wdata  input  XLEN  store data.
REQ-014 ls_req_wmask  input  8  store byte mask.
REQ-015 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-016 ls_resp_valid  output  1  load data / store ack, one-cycle pulse.
REQ-017 ls_resp_data  output  XLEN  load read data.
REQ-018 mem_req_valid / mem_req_ready  output / input  1 / 1  downstream request handshake.
REQ-019 mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  output  XLEN, 1, XLEN, 8  downstream request fields.
REQ-020 mem_resp_valid / mem_resp_data  input  1 / XLEN  downstream response.

Function
REQ-021 FSM states: IDLE, REQ, WAIT; at most one outstanding transaction.
REQ-022 IDLE: arbitrate combinationally.
- Priority to LSU by default.
- IF wins when starve_cnt == STARVE_MAX and if_req_valid.
REQ-023 In IDLE, only the winner's *_req_ready is 1; both readys are 0 in REQ and WAIT.
REQ-024 On a valid&ready handshake, register addr/wen/wdata/wmask and owner, then go to REQ.
- IF requests register wen=0, wmask=0.
- LSU loads force the registered wmask to 0.
REQ-025 REQ: mem_req_valid=1 with registered fields held stable until mem_req_ready; go to WAIT on mem_req_ready.
REQ-026 WAIT: on mem_resp_valid, assert the owner's *_resp_valid for that same cycle with *_resp_data = mem_resp_data, and return to IDLE.
- The non-owner's resp_valid stays 0.
REQ-027 mem_resp_valid in IDLE or REQ is ignored.
REQ-028 Minimum latency: request accept cycle N, mem_req_valid in N+1; with ready at N+1 and response at N+2, resp_valid pulses at N+2.
- A new request is accepted at N+3 at the earliest.
REQ-029 starve_cnt (width fits STARVE_MAX):
- Increments, saturating at STARVE_MAX, on each LSU grant while if_req_valid=1.
- Clears on any IF grant, or on an LSU grant with if_req_valid=0.
REQ-030 Stores complete through a response: ls_resp_valid pulses; ls_resp_data is don't-care.
REQ-031 A requester may drop valid before ready; no state changes without a handshake.

Reset
REQ-032 rst=1 at a clock edge forces:
- state=IDLE, starve_cnt=0, owner=IF.
- Registered request fields cleared to 0.
REQ-033 While rst=1 and on the first cycle after reset: all *_ready, *_resp_valid and mem_req_valid outputs are 0.
REQ-034 Reset mid-transaction (REQ or WAIT) abandons the transaction.
- No resp_valid pulse is issued.
- A later stale mem_resp_valid is ignored per REQ-027.

Verification
REQ-035 IF read only: if_req addr 0x8000_0000, mem_req_ready=1 immediately, response 0x1122_3344_5566_7788 one cycle later -> if_resp_valid one pulse with that data; ls_resp_valid stays 0.
REQ-036 IF and LSU load both valid in IDLE -> LSU granted first; IF granted on the next IDLE.
REQ-037 LSU valid continuously, IF valid continuously -> grant sequence LSU x4, IF, LSU x4, IF.
REQ-038 Store wdata 0xDEAD_BEEF, wmask 0x0F, mem_req_ready delayed 3 cycles -> mem_req fields stable for all 4 cycles; ls_resp_valid on response.
REQ-039 Load with wmask=0xFF -> mem_req_wmask=0x00 and mem_req_wen=0.
REQ-040 rst asserted in WAIT, then mem_resp_valid -> no resp_valid pulse; state IDLE; the next IF request completes normally.
